// File: rtl/nn_float_pkg.sv
// Shared float32 definitions for the NN output-layer blocks: field widths,
// comparator flag encodings and the arg-max FSM state type.
package nn_float_pkg;

  localparam int FLOAT_W = 32;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;

  // Comparator flag is {a>b, a==b, a<b}, exactly one bit set.
  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_EQ = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/float_argmax_cmp.sv
// Combinational float32 comparator. Orders operands by sign, then by the
// {exp, mant} magnitude; +0 ranks above -0, and NaN/Inf are ordered purely by
// their bit pattern (no NaN detection).
module float_argmax_cmp
  import nn_float_pkg::*;
(
  input  logic [FLOAT_W-1:0] a,
  input  logic [FLOAT_W-1:0] b,
  output logic [2:0]         flag
);

  logic                      sign_a;
  logic                      sign_b;
  logic [EXP_W+MANT_W-1:0]   mag_a;
  logic [EXP_W+MANT_W-1:0]   mag_b;

  assign sign_a = a[FLOAT_W-1];
  assign sign_b = b[FLOAT_W-1];
  assign mag_a  = {a[MANT_W +: EXP_W], a[MANT_W-1:0]};
  assign mag_b  = {b[MANT_W +: EXP_W], b[MANT_W-1:0]};

  // Sign decides first; within a sign, magnitude order flips for negatives.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the branches can leave it unassigned and infer a latch.
    flag = FLAG_EQ;
    if (a == b) begin
      flag = FLAG_EQ;
    end else if (sign_a != sign_b) begin
      flag = sign_a ? FLAG_LT : FLAG_GT;
    end else if (!sign_a) begin
      flag = (mag_a > mag_b) ? FLAG_GT : FLAG_LT;
    end else begin
      flag = (mag_a < mag_b) ? FLAG_GT : FLAG_LT;
    end
  end

endmodule

// File: rtl/float_argmax.sv
// Streaming arg-max over one vector of float32 scores (one per beat, ending
// with in_last). Reports the index and value of the largest score; ties keep
// the earliest index. Vectors longer than N_MAX flag out_ovf and pin the
// index of any later maximum at N_MAX-1.
module float_argmax
  import nn_float_pkg::*;
#(
  parameter int N_MAX = 16,
  parameter int IDX_W = $clog2(N_MAX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOAT_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [FLOAT_W-1:0] out_max,
  output logic               out_ovf
);

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N_MAX - 1);

  state_t             state;
  state_t             state_nx;
  logic [FLOAT_W-1:0] max_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   count;
  logic               ovf_r;
  logic [2:0]         flag;
  logic               accept;

  // Ready in IDLE/ACCUM only, and held low while reset is asserted.
  assign in_ready = rst_n && ((state == IDLE) || (state == ACCUM));
  assign accept   = in_valid && in_ready;

  float_argmax_cmp u_cmp (
    .a    (in_data),
    .b    (max_r),
    .flag (flag)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: first beat, accumulate until in_last, hold until consumed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = in_last ? DONE : ACCUM;
      ACCUM:   if (accept && in_last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Running maximum, its index, the saturating beat counter and overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_r <= '0;
      idx_r <= '0;
      count <= '0;
      ovf_r <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        max_r <= in_data;
        idx_r <= '0;
        count <= IDX_W'(1);
        ovf_r <= 1'b0;
      end else begin
        if (flag == FLAG_GT) begin
          max_r <= in_data;
          idx_r <= count;
        end
        if (count != CNT_LAST) count <= count + IDX_W'(1);
        else if (!in_last)     ovf_r <= 1'b1;
      end
    end
  end

  assign out_valid = (state == DONE);
  assign out_idx   = idx_r;
  assign out_max   = max_r;
  assign out_ovf   = ovf_r;

endmodule

// File: doc/float_argmax.md
Name: float_argmax

Overview:
- Streaming arg-max unit at the NN output layer. Downstream of the float32 comparator.
- Consumes one vector of IEEE-754 single-precision scores, one score per beat, terminated by in_last.
- Returns the index and value of the largest score; this is the classification result.
- Each incoming score is compared against the running maximum using the codebase float32 comparator, whose flag is {a>b, a==b, a<b}.

Parameters:
- N_MAX, 16, maximum number of scores per vector.
- IDX_W, $clog2(N_MAX), width of the index and of the element counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block can accept a score beat.
- in_data  in  32  float32 score {sign, exp[7:0], mant[22:0]}.
- in_last  in  1  final score of the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  IDX_W  index of the maximum score (0 = first beat).
- out_max  out  32  maximum score value.
- out_ovf  out  1  vector exceeded N_MAX beats.

Behaviour:
- Reset (rst_n sampled low at a clk edge):
  - state=IDLE, in_ready=0 during reset, out_valid=0, out_idx=0, out_max=0, out_ovf=0, count=0.
  - Reset is synchronous only. Asserting it mid-vector or while a result is held discards all progress with no output.
- Accept rule: a beat is accepted on a clk edge where in_valid && in_ready. in_ready = (state==IDLE || state==ACCUM).
- IDLE:
  - On an accepted beat: load max_r=in_data, idx_r=0, count=1, ovf_r=0.
  - If in_last is also set, go to DONE; otherwise go to ACCUM.
  - No comparison is made on the first beat.
- ACCUM, on an accepted beat:
  - Comparator inputs: a=in_data, b=max_r.
  - If flag==3'b100 (strictly greater): max_r<=in_data and idx_r<=count.
  - On equal or less, keep max_r and idx_r. Ties resolve to the earliest index.
  - count<=count+1.
  - If count==N_MAX-1 and in_last=0: set ovf_r.
  - Once ovf_r is set, further beats are still accepted and compared, count saturates at N_MAX-1, and new maxima there record idx N_MAX-1.
  - If in_last: go to DONE.
- DONE:
  - out_valid=1; out_idx, out_max and out_ovf are driven from registers and held stable while out_valid && !out_ready.
  - in_ready=0 for the whole state.
  - On out_valid && out_ready: go to IDLE and clear out_valid. The next beat can be accepted one cycle later; there is no same-cycle turnaround.
- Latency: out_valid rises on the clk edge after the in_last beat is accepted (1 cycle). Throughput is one score per cycle within a vector.
- Comparison semantics are inherited from the comparator and are not altered:
  - Ordering is bitwise sign/exp/mant; +0 (0x00000000) > -0 (0x80000000).
  - NaN and Inf are ordered by their bit pattern (exp=0xFF treated as the largest exponent).
  - No NaN detection in this block.
- Outputs change only on clk edges. No combinational path from in_data to out_*.
- in_valid while in DONE: ignored, not accepted; the upstream stage holds its beat.

Decomposition:
- Package nn_float_pkg:
  - FLOAT_W=32, EXP_W=8, MANT_W=23.
  - Comparator flag localparams FLAG_GT=3'b100, FLAG_EQ=3'b010, FLAG_LT=3'b001.
  - State enum {IDLE, ACCUM, DONE}.
- Sub-module: one instance of the existing float32 comparator, combinational, in the ACCUM datapath.
- The FSM, counter and registers live in float_argmax itself.

Test Plan:
- Beats 0x3F800000 (1.0), 0x40000000 (2.0), 0x3F000000 (0.5, last) -> out_idx=1, out_max=0x40000000, out_valid one cycle after the last beat.
- Negatives 0xC0400000 (-3.0), 0xBF800000 (-1.0), 0xC0000000 (-2.0, last) -> out_idx=1, out_max=0xBF800000.
- Tie 0x40000000, 0x40000000 (last); and signed zeros 0x80000000, 0x00000000 (last) -> tie gives idx=0; zeros give idx=1, max=0x00000000.
- Single beat 0x41200000 with in_last -> idx=0, max=0x41200000, out_ovf=0. Then hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; release -> IDLE next cycle.
- N_MAX=16: send 17 beats of increasing value, last on beat 17 -> out_ovf=1, out_idx=15, out_max=beat 17 value.
- Pull rst_n low mid-vector (after 3 beats) and while in DONE -> next cycle out_valid=0, state IDLE; a fresh 2-beat vector then yields the correct result.
